// File: rtl/end_screen_fader.sv
// End-screen fader: scales the palette mapper's 4-bit RGB by a frame-synchronous
// gain (0..16) to fade the end screen in, hold it, and fade it out again.
//
// Ports:
//   vga_clk                      pixel clock
//   reset                        synchronous, active-high reset
//   start                        one-cycle pulse, begin fade-in (honoured only in IDLE)
//   dismiss                      one-cycle pulse, leave HOLD early (honoured only in HOLD)
//   DrawX, DrawY                 current pixel column/row (mapper input timing)
//   blank                        1 = visible region, same timing as DrawX
//   red_in, green_in, blue_in    mapper colour, valid one cycle after DrawX
//   red, green, blue             faded colour, two cycles after DrawX
//   busy                         1 in any state other than IDLE
//   done                         one-cycle pulse on FADE_OUT -> IDLE
module end_screen_fader #(
    parameter int unsigned FRAMES_PER_STEP = 4,
    parameter int unsigned HOLD_FRAMES     = 120,
    parameter int unsigned H_LAST          = 639,
    parameter int unsigned V_LAST          = 479
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       start,
    input  logic       dismiss,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       blank,
    input  logic [3:0] red_in,
    input  logic [3:0] green_in,
    input  logic [3:0] blue_in,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       busy,
    output logic       done
);

    localparam logic [9:0]  HLastW   = 10'(H_LAST);
    localparam logic [9:0]  VLastW   = 10'(V_LAST);
    localparam logic [15:0] StepLast = 16'(FRAMES_PER_STEP - 1);
    localparam logic [15:0] HoldLast = 16'(HOLD_FRAMES - 1);
    localparam bit          HoldAuto = (HOLD_FRAMES != 0);

    typedef enum logic [1:0] {
        StIdle,
        StFadeIn,
        StHold,
        StFadeOut
    } state_e;

    state_e      r_state;
    logic [4:0]  r_gain;
    logic [15:0] r_cnt;
    logic        r_start_flag;
    logic        r_dismiss_flag;
    logic        r_frame_tick;
    logic        r_blank_d;
    logic [3:0]  r_red;
    logic [3:0]  r_green;
    logic [3:0]  r_blue;
    logic        r_busy;
    logic        r_done;

    logic        w_frame_end;
    logic [7:0]  w_red_prod;
    logic [7:0]  w_green_prod;
    logic [7:0]  w_blue_prod;

    assign w_frame_end  = (DrawX == HLastW) && (DrawY == VLastW);

    // 4-bit colour times 5-bit gain fits in 8 bits (15 * 16 = 240); >> 4 keeps [7:4].
    assign w_red_prod   = {4'b0, red_in}   * {3'b0, r_gain};
    assign w_green_prod = {4'b0, green_in} * {3'b0, r_gain};
    assign w_blue_prod  = {4'b0, blue_in}  * {3'b0, r_gain};

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_state        <= StIdle;
            r_gain         <= 5'd0;
            r_cnt          <= 16'd0;
            r_start_flag   <= 1'b0;
            r_dismiss_flag <= 1'b0;
            r_frame_tick   <= 1'b0;
            r_blank_d      <= 1'b0;
            r_red          <= 4'h0;
            r_green        <= 4'h0;
            r_blue         <= 4'h0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_end;

            // Pixel path: blank is delayed once so it lines up with the mapper colour.
            r_blank_d <= blank;
            r_red     <= r_blank_d ? w_red_prod[7:4]   : 4'h0;
            r_green   <= r_blank_d ? w_green_prod[7:4] : 4'h0;
            r_blue    <= r_blank_d ? w_blue_prod[7:4]  : 4'h0;

            r_done <= 1'b0;

            // Requests are latched only in the state that can use them; the
            // transition branches below clear them, overriding these sets.
            if (start && (r_state == StIdle)) begin
                r_start_flag <= 1'b1;
            end
            if (dismiss && (r_state == StHold)) begin
                r_dismiss_flag <= 1'b1;
            end

            // State and gain change only on frame boundaries.
            if (r_frame_tick) begin
                unique case (r_state)
                    StIdle: begin
                        // A start arriving on the tick itself is honoured immediately.
                        if (r_start_flag || start) begin
                            r_state      <= StFadeIn;
                            r_busy       <= 1'b1;
                            r_start_flag <= 1'b0;
                            r_cnt        <= 16'd0;
                            r_gain       <= 5'd0;
                        end
                    end
                    StFadeIn: begin
                        if (r_cnt == StepLast) begin
                            r_cnt <= 16'd0;
                            if (r_gain != 5'd16) begin
                                r_gain <= r_gain + 5'd1;
                            end
                            if (r_gain >= 5'd15) begin
                                r_state <= StHold;
                            end
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    StHold: begin
                        if (r_dismiss_flag || dismiss) begin
                            r_state        <= StFadeOut;
                            r_cnt          <= 16'd0;
                            r_dismiss_flag <= 1'b0;
                            r_gain         <= 5'd16;
                        end else if (HoldAuto) begin
                            if (r_cnt == HoldLast) begin
                                r_state        <= StFadeOut;
                                r_cnt          <= 16'd0;
                                r_dismiss_flag <= 1'b0;
                                r_gain         <= 5'd16;
                            end else begin
                                r_cnt <= r_cnt + 16'd1;
                            end
                        end
                    end
                    StFadeOut: begin
                        if (r_cnt == StepLast) begin
                            r_cnt <= 16'd0;
                            if (r_gain != 5'd0) begin
                                r_gain <= r_gain - 5'd1;
                            end
                            if (r_gain <= 5'd1) begin
                                r_state <= StIdle;
                                r_gain  <= 5'd0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign red   = r_red;
    assign green = r_green;
    assign blue  = r_blue;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_end_screen_fader.sv
// Bench for end_screen_fader: two instances (step 1 / manual hold, step 2 / 2-frame hold)
// share one stimulus stream; a phase/frame-count model predicts every output each cycle.
module tb_end_screen_fader;

    localparam int unsigned HL = 15;   // last visible column
    localparam int unsigned VL = 3;    // last visible row
    localparam int unsigned HT = 20;   // columns per line incl. blanking
    localparam int unsigned VT = 6;    // lines per frame incl. blanking

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       dismiss = 1'b0;
    logic       blank = 1'b0;
    logic [9:0] dx = '0;
    logic [9:0] dy = '0;
    logic [3:0] rin = '0;
    logic [3:0] gin = '0;
    logic [3:0] bin = '0;

    logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b;
    logic       a_busy, a_done, b_busy, b_done;

    always #5 clk = ~clk;

    end_screen_fader #(
        .FRAMES_PER_STEP(1),
        .HOLD_FRAMES    (0),
        .H_LAST         (HL),
        .V_LAST         (VL)
    ) dut_a (
        .vga_clk (clk),
        .reset   (rst),
        .start   (start),
        .dismiss (dismiss),
        .DrawX   (dx),
        .DrawY   (dy),
        .blank   (blank),
        .red_in  (rin),
        .green_in(gin),
        .blue_in (bin),
        .red     (a_r),
        .green   (a_g),
        .blue    (a_b),
        .busy    (a_busy),
        .done    (a_done)
    );

    end_screen_fader #(
        .FRAMES_PER_STEP(2),
        .HOLD_FRAMES    (2),
        .H_LAST         (HL),
        .V_LAST         (VL)
    ) dut_b (
        .vga_clk (clk),
        .reset   (rst),
        .start   (start),
        .dismiss (dismiss),
        .DrawX   (dx),
        .DrawY   (dy),
        .blank   (blank),
        .red_in  (rin),
        .green_in(gin),
        .blue_in (bin),
        .red     (b_r),
        .green   (b_g),
        .blue    (b_b),
        .busy    (b_busy),
        .done    (b_done)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Scan position, mapper emulation mode (0 const white, 1 random, 2 alignment pattern).
    int sx = 0, sy = 0, px = 0;
    int mode = 0;
    int tick_seen = 0;
    int base = 0;
    int a_done_cnt = 0, b_done_cnt = 0;

    // Model: phase 0 idle, 1 fade-in, 2 hold, 3 fade-out; m_n = frame ticks spent in phase.
    int p_fps [2] = '{1, 2};
    int p_hold[2] = '{0, 2};
    int m_ph[2], m_n[2], m_sf[2], m_df[2], m_tk[2], m_bd[2], m_done[2];
    int m_r[2], m_g[2], m_b[2];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int gain_of(input int ph, input int n, input int f);
        case (ph)
            1:       return n / f;
            2:       return 16;
            3:       return 16 - n / f;
            default: return 0;
        endcase
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int g;
            int f;
            int pre;
            if (rst) begin
                m_ph[i] = 0; m_n[i] = 0; m_sf[i] = 0; m_df[i] = 0; m_tk[i] = 0;
                m_bd[i] = 0; m_done[i] = 0; m_r[i] = 0; m_g[i] = 0; m_b[i] = 0;
            end else begin
                f = p_fps[i];
                g = gain_of(m_ph[i], m_n[i], f);
                m_r[i] = (m_bd[i] != 0) ? (int'(rin) * g) >> 4 : 0;
                m_g[i] = (m_bd[i] != 0) ? (int'(gin) * g) >> 4 : 0;
                m_b[i] = (m_bd[i] != 0) ? (int'(bin) * g) >> 4 : 0;
                m_bd[i] = int'(blank);
                pre = m_ph[i];
                m_done[i] = 0;
                if (m_tk[i] != 0) begin
                    case (pre)
                        0: if (m_sf[i] != 0 || start) begin
                            m_ph[i] = 1; m_n[i] = 0; m_sf[i] = 0;
                        end
                        1: begin
                            m_n[i]++;
                            if (m_n[i] == 16 * f) begin m_ph[i] = 2; m_n[i] = 0; end
                        end
                        2: begin
                            m_n[i]++;
                            if (m_df[i] != 0 || dismiss || (p_hold[i] != 0 && m_n[i] == p_hold[i]))
                            begin
                                m_ph[i] = 3; m_n[i] = 0; m_df[i] = 0;
                            end
                        end
                        default: begin
                            m_n[i]++;
                            if (m_n[i] == 16 * f) begin m_ph[i] = 0; m_n[i] = 0; m_done[i] = 1; end
                        end
                    endcase
                end
                if (pre == 0 && m_ph[i] == 0 && start) m_sf[i] = 1;
                if (pre == 2 && m_ph[i] == 2 && dismiss) m_df[i] = 1;
                m_tk[i] = (int'(dx) == int'(HL) && int'(dy) == int'(VL)) ? 1 : 0;
            end
        end
    endtask

    // One pixel clock: drive, clock, update model, compare, advance scan.
    task automatic step();
        logic kill;
        kill = 1'b0;
        if (mode == 1) begin
            if ($urandom_range(0, 299) == 0) start = 1'b1;
            if ($urandom_range(0, 199) == 0) dismiss = 1'b1;
            // Cycle in which the frame tick is high inside the DUT.
            if (sx == int'(HL) + 1 && sy == int'(VL)) begin
                if ($urandom_range(0, 3) == 0) start = 1'b1;
                if ($urandom_range(0, 2) == 0) dismiss = 1'b1;
            end
            if ($urandom_range(0, 5999) == 0) rst = 1'b1;
            kill = ($urandom_range(0, 7) == 0);
        end else if (mode == 2) begin
            kill = (sx == 13 && sy == 1);
        end
        dx = 10'(sx);
        dy = 10'(sy);
        blank = (sx <= int'(HL) && sy <= int'(VL)) && !kill;
        case (mode)
            1: begin rin = 4'($urandom); gin = 4'($urandom); bin = 4'($urandom); end
            2: begin
                rin = (px == 10) ? 4'hA : (px == 13) ? 4'hF : 4'h5;
                gin = rin;
                bin = rin;
            end
            default: begin rin = 4'hF; gin = 4'hF; bin = 4'hF; end
        endcase
        @(posedge clk);
        model_edge();
        #1;
        check("a_rgb", {20'd0, a_r, a_g, a_b}, 32'((m_r[0] << 8) | (m_g[0] << 4) | m_b[0]));
        check("a_busy", {31'd0, a_busy}, (m_ph[0] != 0) ? 32'd1 : 32'd0);
        check("a_done", {31'd0, a_done}, 32'(m_done[0]));
        check("b_rgb", {20'd0, b_r, b_g, b_b}, 32'((m_r[1] << 8) | (m_g[1] << 4) | m_b[1]));
        check("b_busy", {31'd0, b_busy}, (m_ph[1] != 0) ? 32'd1 : 32'd0);
        check("b_done", {31'd0, b_done}, 32'(m_done[1]));
        if (a_done === 1'b1) a_done_cnt++;
        if (b_done === 1'b1) b_done_cnt++;
        if (sx == int'(HL) && sy == int'(VL)) tick_seen++;
        px = sx;
        sx++;
        if (sx == int'(HT)) begin
            sx = 0;
            sy = (sy + 1 == int'(VT)) ? 0 : sy + 1;
        end
        start = 1'b0;
        dismiss = 1'b0;
        rst = 1'b0;
    endtask

    // Step until (xx,yy) has just been applied.
    task automatic run_until(input int xx, input int yy);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!(px == xx && sx == xx + 1 && ((sx == 0) ? 1 : 1) == 1 && cur_row(yy))
                   && k < int'(2 * HT * VT));
        if (k >= int'(2 * HT * VT)) check("run_until_timeout", 32'd0, 32'd1);
    endtask

    // Row of the last applied pixel equals yy (scan never wraps mid-row for xx < HT-1).
    function automatic bit cur_row(input int yy);
        return sy == yy;
    endfunction

    task automatic run_ticks(input int n);
        int target;
        int k;
        target = tick_seen + n;
        k = 0;
        while (tick_seen < target && k < (n + 1) * int'(HT * VT)) begin
            step();
            k++;
        end
        if (tick_seen < target) check("run_ticks_timeout", 32'd0, 32'd1);
    endtask

    // Advance to the visible pixel (8,1) of the frame following tick k after base.
    task automatic at_tick(input int k);
        if (tick_seen - base < k) run_ticks(k - (tick_seen - base));
        run_until(8, 1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = 0; m_n[i] = 0; m_sf[i] = 0; m_df[i] = 0; m_tk[i] = 0;
            m_bd[i] = 0; m_done[i] = 0; m_r[i] = 0; m_g[i] = 0; m_b[i] = 0;
        end

        // Reset, then three idle frames of white input.
        mode = 0;
        rst = 1'b1; step();
        rst = 1'b1; step();
        run_ticks(3);
        run_until(8, 1);
        check("idle_red", {28'd0, a_r}, 32'd0);
        check("idle_busy", {31'd0, a_busy}, 32'd0);
        check("idle_done_cnt", 32'(a_done_cnt + b_done_cnt), 32'd0);

        // Start mid-frame: gain must stay 0 until the frame boundary.
        start = 1'b1; step();
        base = tick_seen;
        run_until(12, 1);
        check("start_frame_red", {28'd0, a_r}, 32'd0);
        check("start_frame_busy", {31'd0, a_busy}, 32'd0);

        at_tick(2);
        check("gain1_red", {28'd0, a_r}, 32'd0);
        check("gain1_busy", {30'd0, a_busy, b_busy}, 32'd3);
        at_tick(9);
        check("a_gain8_red", {28'd0, a_r}, 32'd7);
        check("b_gain4_red", {28'd0, b_r}, 32'd3);
        at_tick(17);
        check("a_gain16_red", {28'd0, a_r}, 32'd15);
        check("b_gain8_red", {28'd0, b_r}, 32'd7);

        // Alignment: colour tagged at DrawX=10 appears two clocks later; blanked pixel is black.
        at_tick(18);
        mode = 2;
        run_until(10, 1);
        check("align_before", {28'd0, a_r}, 32'd5);
        step();
        check("align_at", {28'd0, a_r}, 32'd10);
        step();
        check("align_after", {28'd0, a_r}, 32'd5);
        step();
        step();
        check("blank_black", {28'd0, a_r}, 32'd0);
        mode = 0;

        // Dismiss three frames into HOLD (manual-hold instance).
        at_tick(20);
        dismiss = 1'b1; step();
        at_tick(21);
        check("a_fadeout_start", {28'd0, a_r}, 32'd15);
        at_tick(22);
        check("a_fadeout_g15", {28'd0, a_r}, 32'd14);

        // Two-frame auto hold on the second instance.
        at_tick(33);
        check("b_hold_red", {28'd0, b_r}, 32'd15);
        at_tick(36);
        check("b_fo_first", {28'd0, b_r}, 32'd15);
        at_tick(37);
        check("b_fo_g15", {28'd0, b_r}, 32'd14);
        check("a_end_busy", {31'd0, a_busy}, 32'd0);
        check("a_done_cnt", 32'(a_done_cnt), 32'd1);
        check("a_end_red", {28'd0, a_r}, 32'd0);
        at_tick(67);
        check("b_end_busy", {31'd0, b_busy}, 32'd0);
        check("b_done_cnt", 32'(b_done_cnt), 32'd1);

        // Reset during fade-in at gain 9, with a stray start issued mid-fade.
        start = 1'b1; step();
        base = tick_seen;
        at_tick(5);
        start = 1'b1; step();
        at_tick(10);
        check("a_gain9_red", {28'd0, a_r}, 32'd8);
        rst = 1'b1; step();
        check("rst_rgb", {20'd0, a_r, a_g, a_b}, 32'd0);
        check("rst_busy", {30'd0, a_busy, b_busy}, 32'd0);
        run_ticks(3);
        run_until(8, 1);
        check("post_rst_busy", {30'd0, a_busy, b_busy}, 32'd0);

        // Randomized traffic against the model.
        mode = 1;
        run_ticks(150);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/end_screen_fader.md
Name: end_screen_fader

Overview:
- Pixel-path stage directly downstream of the end-screen ROM/palette mapper, clocked on vga_clk.
- Takes the mapper's registered 4-bit RGB and scales it by a frame-synchronous gain, giving fade-in, hold and fade-out of the end screen.
- Sequencing is set by a frame-counting state machine that advances only at frame boundaries, so gain never changes mid-frame.
- Outputs feed the VGA RGB pins (via the top-level screen select).

Parameters:
- FRAMES_PER_STEP, 4, frames per gain step of 1 (range 1..255).
- HOLD_FRAMES, 120, frames spent at full gain before auto fade-out; 0 = hold until dismiss.
- H_LAST, 639, last visible DrawX.
- V_LAST, 479, last visible DrawY.

Ports:
- vga_clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: begin fade-in.
- dismiss  in  1  one-cycle pulse: leave HOLD early.
- DrawX  in  10  current pixel column, same timing as the mapper's input.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = visible region, same timing as DrawX.
- red_in  in  4  mapper red, valid one cycle after DrawX.
- green_in  in  4  mapper green, valid one cycle after DrawX.
- blue_in  in  4  mapper blue, valid one cycle after DrawX.
- red  out  4  faded red.
- green  out  4  faded green.
- blue  out  4  faded blue.
- busy  out  1  1 in any state other than IDLE.
- done  out  1  one-cycle pulse on the FADE_OUT -> IDLE transition.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; gain = 0; frame counter = 0.
  - red, green and blue = 0; busy = 0; done = 0; blank_d = 0.
- frame_tick:
  - Registered, one-cycle pulse in the cycle after DrawX == H_LAST && DrawY == V_LAST.
  - Only state and gain updates occur on frame_tick; start and dismiss are captured into sticky flags and serviced at the next frame_tick.
- gain: 5-bit, range 0..16.
- Pixel path, one register stage:
  - blank_d = blank delayed 1 cycle, aligned with red_in.
  - Next-cycle output = blank_d ? (in * gain) >> 4 : 0, computed per channel as an 8-bit product truncated to 4 bits.
  - gain = 16 gives exact passthrough; gain = 0 gives black.
  - Total latency from DrawX to output = 2 cycles.
- States:
  - IDLE: gain = 0. On frame_tick with start_flag set, clear start_flag and go to FADE_IN.
  - FADE_IN: frame counter counts frame_ticks. On the FRAMES_PER_STEP-th tick, reset the counter and add 1 to gain. When gain reaches 16, reset the counter and go to HOLD.
  - HOLD: gain = 16. Leave to FADE_OUT on either:
    - frame_tick with dismiss_flag set, or
    - HOLD_FRAMES != 0 and the frame count reaches HOLD_FRAMES.
  - FADE_OUT: gain decrements by 1 every FRAMES_PER_STEP frame_ticks. When gain reaches 0, go to IDLE and pulse done for one cycle.
- Boundary conditions:
  - start outside IDLE: ignored and not latched.
  - dismiss outside HOLD: ignored. A dismiss during FADE_IN is not latched.
  - start and dismiss in the same cycle: each is handled per its own rule.
  - start coincident with frame_tick in IDLE: takes effect at that tick.
  - Gain saturates at both ends; there is no wrap from 16 to 17 or from 0 to 31.
  - reset mid-fade: the next cycle is IDLE with gain = 0 and black output; all flags are cleared.
- Timing: full fade-in takes 16*FRAMES_PER_STEP frames; the full sequence with HOLD_FRAMES != 0 takes 32*FRAMES_PER_STEP + HOLD_FRAMES frames.

Test Plan:
- Reset, then drive blank = 1 and red_in = F for 3 frames -> red = 0, busy = 0, done never asserts.
- FRAMES_PER_STEP = 1:
  - Pulse start mid-frame -> gain stays 0 for the rest of that frame.
  - Next frame: red_in = F gives red = 0 (gain 1: 15*1 >> 4 = 0).
  - At gain 8: red_in = F gives red = 7.
  - gain reaches 16 after 16 frame_ticks; red = F, state HOLD.
- HOLD_FRAMES = 0, dismiss pulsed 3 frames into HOLD -> FADE_OUT starts at the following frame_tick. After 16 ticks gain = 0, done is high for exactly 1 cycle, busy falls.
- HOLD_FRAMES = 2 -> HOLD lasts exactly 2 frames, then fade-out with no dismiss.
- Alignment check: at gain = 16, DrawX = 100 with a known red_in value -> red shows that value exactly 2 cycles after DrawX = 100. With blank = 0 while red_in = F -> red = 0.
- Assert reset at gain = 9 during FADE_IN -> next cycle red = green = blue = 0, busy = 0. A start pulsed during FADE_IN before the reset has no effect afterward.
